// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM command-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  localparam int ARB_MAX_PORTS = 8;

  // Port-index width; never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin picker: scans from last+1 upward (mod N_PORTS) and
// returns the first pending port as a one-hot grant plus its index.
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = arb_idx_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]   last,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = (int'(last) + k) % N_PORTS;
      if (!any && pending[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM core command port among N_PORTS requesters,
// one transaction outstanding. Define SDRAM_ARB_FIXED_PRI0_EN to give port 0 absolute priority.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             req_rd,
  input  logic [N_PORTS*BE_WIDTH-1:0]    req_wr,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [N_PORTS-1:0]             req_ack,
  output logic [N_PORTS-1:0]             req_rvalid,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  output logic                           mem_rd,
  output logic [BE_WIDTH-1:0]            mem_wr,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic                           mem_rdy,
  input  logic                           mem_rvalid,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           err
);

  localparam int IDX_W = arb_idx_w(N_PORTS);

  arb_state_t               state, state_nx;
  logic [IDX_W-1:0]         last, owner;
  logic                     hold_rd;
  logic [BE_WIDTH-1:0]      hold_wr;
  logic [ADDR_WIDTH-1:0]    hold_addr;
  logic [DATA_WIDTH-1:0]    hold_wdata;
  logic [N_PORTS-1:0]       vld_p1;
  logic [DATA_WIDTH-1:0]    rdata_p1;

  logic [N_PORTS-1:0]       pending, pick_pending, rr_grant, win_grant, ack;
  logic [IDX_W-1:0]         rr_idx, win_idx;
  logic                     rr_any, upd_last, grant_en;
  logic                     sel_rd;
  logic [BE_WIDTH-1:0]      sel_wr;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_PORTS; i++)
      pending[i] = req_rd[i] | (|req_wr[i*BE_WIDTH +: BE_WIDTH]);
  end

`ifdef SDRAM_ARB_FIXED_PRI0_EN
  // Port 0 bypasses the rotation entirely and never moves the pointer.
  assign pick_pending = {pending[N_PORTS-1:1], 1'b0};
  assign win_grant    = pending[0] ? N_PORTS'(1) : rr_grant;
  assign win_idx      = pending[0] ? '0 : rr_idx;
  assign upd_last     = ~pending[0];
`else
  assign pick_pending = pending;
  assign win_grant    = rr_grant;
  assign win_idx      = rr_idx;
  assign upd_last     = 1'b1;
`endif

  sdram_rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .pending (pick_pending),
    .last    (last),
    .grant   (rr_grant),
    .idx     (rr_idx),
    .any     (rr_any)
  );

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win_grant[i]) begin
        sel_rd    = req_rd[i];
        sel_wr    = req_wr[i*BE_WIDTH +: BE_WIDTH];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ack is combinational; it is masked while reset is held so no grant escapes.
  always_comb begin
    state_nx = state;
    ack      = '0;
    grant_en = 1'b0;
    case (state)
      IDLE: begin
        if ((|pending) && !rst) begin
          grant_en = 1'b1;
          ack      = win_grant;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rdy) state_nx = hold_rd ? WAIT_RD : IDLE;
      end
      WAIT_RD: begin
        if (mem_rvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IDX_W'(N_PORTS - 1);
      owner      <= '0;
      hold_rd    <= 1'b0;
      hold_wr    <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_en) begin
        owner      <= win_idx;
        if (upd_last) last <= win_idx;
        hold_rd    <= sel_rd;
        hold_wr    <= sel_rd ? '0 : sel_wr;
        hold_addr  <= sel_addr;
        hold_wdata <= sel_wdata;
      end
      if (mem_rvalid && state != WAIT_RD) err <= 1'b1;
    end
  end

  // ---- read-return stage p1: core data registered and routed to owner ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= '0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= '0;
      rdata_p1 <= '0;
      if (state == WAIT_RD && mem_rvalid) begin
        vld_p1[owner] <= 1'b1;
        rdata_p1      <= mem_rdata;
      end
    end
  end

  assign req_ack    = ack;
  assign req_rvalid = vld_p1;
  assign req_rdata  = rdata_p1;
  assign mem_rd     = (state == ISSUE) & hold_rd;
  assign mem_wr     = (state == ISSUE) ? hold_wr    : '0;
  assign mem_addr   = (state == ISSUE) ? hold_addr  : '0;
  assign mem_wdata  = (state == ISSUE) ? hold_wdata : '0;

  logic unused_ok;
  assign unused_ok = rr_any;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (default 4 ports, 24-bit addr, 16-bit data).
module tb_sdram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BE = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_rd = '0;
  logic [N*BE-1:0]   req_wr = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_ack, req_rvalid;
  logic [DW-1:0]     req_rdata;
  logic              mem_rd;
  logic [BE-1:0]     mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_rdy = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  int            exp_g [6] = '{0, 1, 3, 0, 1, 3};
  logic [DW-1:0] pdata [4] = '{16'h1234, 16'h5678, 16'h0000, 16'h9ABC};
  logic [AW-1:0] paddr [4] = '{24'h000010, 24'h000020, 24'h000000, 24'h000030};

  sdram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ack    (req_ack),
    .req_rvalid (req_rvalid),
    .req_rdata  (req_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic rd, input logic [BE-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd[p]              = rd;
    req_wr[p*BE +: BE]     = be;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*DW +: DW]  = d;
  endtask

  task automatic clr_all();
    req_rd = '0;
    req_wr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_ack;
    int g;

    // Reset state
    cyc();
    cyc();
    cyc();
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_rvalid", 32'(req_rvalid), 0);
    chk("rst_rdata", 32'(req_rdata), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;

    // Single write on port 2
    cyc();
    mem_rdy = 1'b1;
    set_req(2, 1'b0, 2'b11, 24'h000100, 16'hA5A5);
    #1;
    chk("wr_ack", 32'(req_ack), 32'h4);
    cyc();
    clr_all();
    #1;
    chk("wr_mem_wr", 32'(mem_wr), 32'h3);
    chk("wr_mem_addr", 32'(mem_addr), 32'h000100);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5A5);
    chk("wr_mem_rd", 32'(mem_rd), 0);
    chk("wr_no_ack", 32'(req_ack), 0);
    cyc();
    chk("wr_idle_mem_wr", 32'(mem_wr), 0);

    // Round-robin reads on ports 0, 1, 3
    do_reset();
    mem_rdy = 1'b1;
    set_req(0, 1'b1, 2'b00, paddr[0], 16'h0);
    set_req(1, 1'b1, 2'b11, paddr[1], 16'h0);
    set_req(3, 1'b1, 2'b00, paddr[3], 16'h0);
    #1;
    chk("rr_ack0", 32'(req_ack), 32'h1);
    for (int t = 0; t < 6; t++) begin
      g = exp_g[t];
      cyc();
      chk("rr_mem_rd", 32'(mem_rd), 1);
      chk("rr_mem_wr", 32'(mem_wr), 0);
      chk("rr_mem_addr", 32'(mem_addr), 32'(paddr[g]));
      cyc();
      mem_rvalid = 1'b1;
      mem_rdata  = pdata[g];
      #1;
      chk("rr_wait_mem_rd", 32'(mem_rd), 0);
      cyc();
      mem_rvalid = 1'b0;
      if (t == 5) clr_all();
      #1;
      chk("rr_rvalid", 32'(req_rvalid), 32'(N'(1) << g));
      chk("rr_rdata", 32'(req_rdata), 32'(pdata[g]));
      exp_ack = (t == 5) ? '0 : N'(1) << exp_g[t+1];
      chk("rr_next_ack", 32'(req_ack), 32'(exp_ack));
    end

    // mem_rdy held low for 20 ISSUE cycles
    cyc();
    mem_rdy = 1'b0;
    set_req(1, 1'b0, 2'b01, 24'h0ABCDE, 16'h5A5A);
    set_req(3, 1'b0, 2'b10, 24'h000333, 16'h3333);
    #1;
    chk("stall_ack", 32'(req_ack), 32'h2);
    cyc();
    for (int c = 0; c < 20; c++) begin
      chk("stall_mem_wr", 32'(mem_wr), 32'h1);
      chk("stall_mem_addr", 32'(mem_addr), 32'h0ABCDE);
      chk("stall_mem_wdata", 32'(mem_wdata), 32'h5A5A);
      chk("stall_no_ack", 32'(req_ack), 0);
      cyc();
    end
    mem_rdy = 1'b1;
    clr_all();
    #1;
    chk("stall_rdy_mem_wr", 32'(mem_wr), 32'h1);
    cyc();
    chk("stall_done_mem_wr", 32'(mem_wr), 0);
    chk("stall_done_ack", 32'(req_ack), 0);

    // Read with mem_rvalid 3 cycles after acceptance; port 0 acked in the return cycle
    set_req(2, 1'b1, 2'b00, 24'h000222, 16'h0);
    #1;
    chk("lat_ack", 32'(req_ack), 32'h4);
    cyc();
    clr_all();
    set_req(0, 1'b0, 2'b10, 24'h000444, 16'hC0DE);
    #1;
    chk("lat_mem_rd", 32'(mem_rd), 1);
    chk("lat_mem_addr", 32'(mem_addr), 32'h000222);
    cyc();
    chk("lat_busy_ack", 32'(req_ack), 0);
    chk("lat_busy_mem_wr", 32'(mem_wr), 0);
    cyc();
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    #1;
    chk("lat_rvalid", 32'(req_rvalid), 32'h4);
    chk("lat_rdata", 32'(req_rdata), 32'hBEEF);
    chk("lat_same_cycle_ack", 32'(req_ack), 32'h1);
    cyc();
    clr_all();
    #1;
    chk("lat_p0_mem_wr", 32'(mem_wr), 32'h2);
    chk("lat_p0_mem_wdata", 32'(mem_wdata), 32'hC0DE);
    chk("lat_rvalid_clear", 32'(req_rvalid), 0);
    chk("lat_rdata_clear", 32'(req_rdata), 0);
    cyc();

    // Spurious mem_rvalid in IDLE
    chk("spur_err_before", 32'(err), 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h7777;
    cyc();
    mem_rvalid = 1'b0;
    #1;
    chk("spur_err", 32'(err), 1);
    chk("spur_no_rvalid", 32'(req_rvalid), 0);
    chk("spur_no_rdata", 32'(req_rdata), 0);
    cyc();
    cyc();
    cyc();
    chk("spur_err_sticky", 32'(err), 1);
    rst = 1'b1;
    #1;
    chk("spur_err_rst", 32'(err), 0);
    cyc();
    rst = 1'b0;

    // Reset asserted in WAIT_RD
    cyc();
    mem_rdy = 1'b1;
    set_req(1, 1'b1, 2'b00, 24'h000111, 16'h0);
    #1;
    chk("wrst_ack", 32'(req_ack), 32'h2);
    cyc();
    clr_all();
    cyc();
    set_req(2, 1'b0, 2'b11, 24'h000202, 16'h2222);
    set_req(3, 1'b0, 2'b11, 24'h000303, 16'h3333);
    #1;
    chk("wrst_wait_mem_rd", 32'(mem_rd), 0);
    rst = 1'b1;
    cyc();
    chk("wrst_mem_rd", 32'(mem_rd), 0);
    chk("wrst_mem_wr", 32'(mem_wr), 0);
    chk("wrst_ack_zero", 32'(req_ack), 0);
    chk("wrst_rvalid", 32'(req_rvalid), 0);
    chk("wrst_rdata", 32'(req_rdata), 0);
    chk("wrst_err", 32'(err), 0);
    #1;
    rst = 1'b0;
    set_req(3, 1'b0, 2'b00, 24'h0, 16'h0);
    set_req(0, 1'b0, 2'b11, 24'h000404, 16'h4444);
    #1;
    chk("wrst_first_grant", 32'(req_ack), 32'h1);

    // Ports 0 and 2 writing continuously
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("cont_issue_no_ack", 32'(req_ack), 0);
      cyc();
`ifdef SDRAM_ARB_FIXED_PRI0_EN
      exp_ack = N'(1);
`else
      exp_ack = (k % 2 == 1) ? N'(4) : N'(1);
`endif
      chk("cont_grant", 32'(req_ack), 32'(exp_ack));
    end
    clr_all();
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
